// File: rtl/fifo_stream_reader_pkg.sv
// rtl/fifo_stream_reader_pkg.sv - shared types and constants for the FIFO stream reader
package fifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] BUF_DEPTH = 2'd2;

endpackage

// File: rtl/stream_buf2.sv
// rtl/stream_buf2.sv - two-entry register FIFO with valid/ready output side
module stream_buf2
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] r_mem0;
  logic [DATA_WIDTH-1:0] r_mem1;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  w_wr;
  logic                  w_rd;

  assign w_wr = in_valid && (r_count != BUF_DEPTH);
  assign w_rd = (r_count != 2'd0) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem0   <= '0;
      r_mem1   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_wr) begin
        if (r_wr_ptr) r_mem1 <= in_data;
        else          r_mem0 <= in_data;
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_rd) r_rd_ptr <= ~r_rd_ptr;
      if (w_wr && !w_rd)      r_count <= r_count + 2'd1;
      else if (!w_wr && w_rd) r_count <= r_count - 2'd1;
    end
  end

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_rd_ptr ? r_mem1 : r_mem0;
  assign count     = r_count;

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - pops a commanded number of words from a FWFT FIFO onto a stream
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [LEN_WIDTH-1:0] L_ONE = LEN_WIDTH'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_issued;
  logic [LEN_WIDTH-1:0]  r_sent;
  logic [LEN_WIDTH-1:0]  w_issued_nxt;
  logic [LEN_WIDTH-1:0]  w_sent_nxt;
  logic                  r_done;
  logic [1:0]            w_cnt;
  logic [1:0]            w_cnt_nxt;
  logic                  w_buf_valid;
  logic [DATA_WIDTH-1:0] w_buf_data;
  logic                  w_cmd_fire;
  logic                  w_pop;
  logic                  w_beat;
  logic                  w_drain_exit;
  logic                  w_cmd_ready;
  logic                  w_busy;
  logic                  w_last;

  stream_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (rd_clk),
    .rst_n    (rd_rst_n),
    .in_valid (w_pop),
    .in_data  (fifo_rd_data),
    .out_valid(w_buf_valid),
    .out_ready(m_ready),
    .out_data (w_buf_data),
    .count    (w_cnt)
  );

  assign w_cmd_fire   = (r_state == ST_IDLE) && cmd_valid;
  assign w_beat       = w_buf_valid && m_ready;
  assign w_issued_nxt = w_pop  ? r_issued + L_ONE : r_issued;
  assign w_sent_nxt   = w_beat ? r_sent + L_ONE   : r_sent;

  // Completion looks at post-update occupancy so done lands the cycle after the final beat
  always_comb begin
    w_cnt_nxt = w_cnt;
    if (w_pop && !w_beat)      w_cnt_nxt = w_cnt + 2'd1;
    else if (!w_pop && w_beat) w_cnt_nxt = w_cnt - 2'd1;
  end

  assign w_drain_exit = (w_sent_nxt == r_len) && (w_cnt_nxt == 2'd0);

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_cmd_fire) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_issued_nxt == r_len) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_drain_exit) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_ready = (r_state == ST_IDLE);
    w_busy      = (r_state != ST_IDLE);
    w_pop       = (r_state == ST_RUN) && !fifo_empty && (w_cnt < BUF_DEPTH) && (r_issued < r_len);
    w_last      = w_buf_valid && (r_sent == r_len - L_ONE);
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_len    <= '0;
      r_issued <= '0;
      r_sent   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DRAIN) && w_drain_exit;
      if (w_cmd_fire) begin
        r_len    <= cmd_len;
        r_issued <= '0;
        r_sent   <= '0;
      end else begin
        r_issued <= w_issued_nxt;
        r_sent   <= w_sent_nxt;
      end
    end
  end

  assign cmd_ready  = w_cmd_ready;
  assign busy       = w_busy;
  assign fifo_rd_en = w_pop;
  assign m_valid    = w_buf_valid;
  assign m_data     = w_buf_data;
  assign m_last     = w_last;
  assign done       = r_done;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int LW = 8;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          m_ready = 1'b0;
  logic          cmd_ready;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  fifo_stream_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 rd_clk = ~rd_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DW-1:0] src_q[$];
  logic          hole = 1'b0;
  logic          rand_mode = 1'b0;
  logic          pop_pending = 1'b0;

  // reference model: words held between FIFO pop and stream beat
  logic [DW-1:0] md_q[$];
  bit md_active = 0, md_drain = 0, md_done_next = 0;
  int md_len = 0, md_issued = 0, md_sent = 0;
  bit e_valid, e_rd_en, e_last;

  int c0 = 0, n_pops = 0, n_beats = 0, n_last = 0, n_done = 0, bad_pops = 0;
  int first_pop_rel = -1, last_pop_rel = -1, first_beat_rel = -1, last_beat_rel = -1, done_rel = -1;
  logic [DW-1:0] last_data = '0;
  logic [DW-1:0] beat_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic update_fifo_if();
    fifo_empty   = hole || (src_q.size() == 0);
    fifo_rd_data = (src_q.size() != 0) ? src_q[0] : '0;
  endtask

  always @(posedge rd_clk) begin
    cyc <= cyc + 1;
    if (pop_pending && src_q.size() != 0) src_q.delete(0);
    #1;
    if (rand_mode) begin
      m_ready = ($urandom_range(0, 3) != 0);
      hole    = ($urandom_range(0, 4) == 0);
    end
    update_fifo_if();
  end

  always @(negedge rd_clk) begin
    if (!rd_rst_n) begin
      check("rst_cmd_ready", int'(cmd_ready), 1);
      check("rst_fifo_rd_en", int'(fifo_rd_en), 0);
      check("rst_m_valid", int'(m_valid), 0);
      check("rst_m_last", int'(m_last), 0);
      check("rst_m_data", int'(m_data), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      md_active = 0; md_drain = 0; md_done_next = 0; md_q.delete();
      pop_pending = 1'b0;
    end else begin
      e_valid = (md_q.size() != 0);
      e_rd_en = md_active && !md_drain && (md_issued < md_len) && !fifo_empty && (md_q.size() < 2);
      e_last  = e_valid && (md_sent == md_len - 1);
      check("cmd_ready", int'(cmd_ready), int'(!md_active));
      check("busy", int'(busy), int'(md_active));
      check("fifo_rd_en", int'(fifo_rd_en), int'(e_rd_en));
      check("m_valid", int'(m_valid), int'(e_valid));
      check("m_last", int'(m_last), int'(e_last));
      check("done", int'(done), int'(md_done_next));
      if (e_valid) check("m_data", int'(m_data), int'(md_q[0]));

      if (cmd_valid && cmd_ready) begin
        c0 = cyc; n_pops = 0; n_beats = 0; n_last = 0; n_done = 0;
        first_pop_rel = -1; last_pop_rel = -1; first_beat_rel = -1; last_beat_rel = -1;
        done_rel = -1; beat_q.delete();
      end
      if (fifo_rd_en) begin
        if (n_pops == 0) first_pop_rel = cyc - c0;
        last_pop_rel = cyc - c0;
        n_pops++;
        if (fifo_empty) bad_pops++;
      end
      if (m_valid && m_ready) begin
        if (n_beats == 0) first_beat_rel = cyc - c0;
        last_beat_rel = cyc - c0;
        n_beats++;
        beat_q.push_back(m_data);
        if (m_last) begin n_last++; last_data = m_data; end
      end
      if (done) begin n_done++; done_rel = cyc - c0; end
      pop_pending = fifo_rd_en;

      md_done_next = 0;
      if (!md_active) begin
        if (cmd_valid) begin
          md_active = 1; md_drain = 0; md_len = int'(cmd_len);
          md_issued = 0; md_sent = 0; md_q.delete();
        end
      end else begin
        if (e_valid && m_ready) begin md_q.delete(0); md_sent++; end
        if (e_rd_en) begin md_q.push_back(fifo_rd_data); md_issued++; end
        if (md_drain && md_sent == md_len && md_q.size() == 0) begin
          md_active = 0; md_done_next = 1;
        end else if (!md_drain && md_issued == md_len) begin
          md_drain = 1;
        end
      end
    end
  end

  task automatic push_words(input int n, input logic [DW-1:0] base, input bit rnd);
    @(posedge rd_clk); #1;
    for (int i = 0; i < n; i++) src_q.push_back(rnd ? DW'($urandom) : base + DW'(i));
    update_fifo_if();
  endtask

  task automatic set_ready(input logic v);
    @(posedge rd_clk); #1;
    m_ready = v;
  endtask

  task automatic send_cmd(input int len);
    int n;
    @(posedge rd_clk); #1;
    cmd_valid = 1'b1;
    cmd_len   = LW'(len);
    n = 0;
    do begin
      @(negedge rd_clk);
      n++;
    end while (!cmd_ready && n < 100);
    check("cmd_accept", int'(cmd_ready), 1);
    @(posedge rd_clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge rd_clk);
      n++;
    end while (!done && n < budget);
    check("done_seen", int'(done), 1);
    repeat (2) @(negedge rd_clk);
    #1;
  endtask

  task automatic wait_rel(input int rel);
    int n;
    n = 0;
    do begin
      @(negedge rd_clk);
      n++;
    end while ((cyc - c0) < rel && n < 100);
    #1;
  endtask

  initial begin
    // reset with words available and a ready sink
    src_q = {8'h11, 8'h22};
    update_fifo_if();
    m_ready = 1'b1;
    repeat (3) @(negedge rd_clk);
    #1;
    check("s1_cmd_ready", int'(cmd_ready), 1);
    check("s1_rd_en", int'(fifo_rd_en), 0);
    check("s1_busy", int'(busy), 0);
    @(posedge rd_clk); #1;
    rd_rst_n = 1'b1;
    repeat (3) @(negedge rd_clk);
    #1;
    check("s1_idle_no_pop", n_pops, 0);
    src_q.delete();

    // len=4, data always available, sink always ready
    push_words(4, 8'hA0, 1'b0);
    send_cmd(4);
    wait_done(50);
    check("s2_pops", n_pops, 4);
    check("s2_first_pop", first_pop_rel, 1);
    check("s2_last_pop", last_pop_rel, 4);
    check("s2_first_beat", first_beat_rel, 2);
    check("s2_last_beat", last_beat_rel, 5);
    check("s2_done_rel", done_rel, 6);
    check("s2_last_count", n_last, 1);
    check("s2_last_data", int'(last_data), 'hA3);
    check("s2_done_count", n_done, 1);

    // sink stalled until cycle 8
    set_ready(1'b0);
    push_words(4, 8'hB0, 1'b0);
    send_cmd(4);
    wait_rel(7);
    check("s3_stall_pops", n_pops, 2);
    check("s3_stall_beats", n_beats, 0);
    set_ready(1'b1);
    wait_done(50);
    check("s3_beats", n_beats, 4);
    for (int i = 0; i < 4; i++)
      check("s3_order", (i < beat_q.size()) ? int'(beat_q[i]) : -1, 'hB0 + i);
    check("s3_done_count", n_done, 1);

    // FIFO runs dry for three cycles after the first pop
    push_words(3, 8'h31, 1'b0);
    send_cmd(3);
    @(posedge rd_clk); #1;
    hole = 1'b1;
    update_fifo_if();
    repeat (3) @(posedge rd_clk);
    #1;
    hole = 1'b0;
    update_fifo_if();
    wait_done(50);
    check("s4_bad_pops", bad_pops, 0);
    check("s4_pops", n_pops, 3);
    for (int i = 0; i < 3; i++)
      check("s4_order", (i < beat_q.size()) ? int'(beat_q[i]) : -1, 'h31 + i);
    check("s4_done_count", n_done, 1);

    // zero-length command
    send_cmd(0);
    wait_done(20);
    repeat (3) @(negedge rd_clk);
    #1;
    check("s5_pops", n_pops, 0);
    check("s5_beats", n_beats, 0);
    check("s5_done_count", n_done, 1);

    // reset in cycle 3 of a len=8 transfer, then a fresh len=2 command
    push_words(8, 8'h40, 1'b0);
    send_cmd(8);
    wait_rel(2);
    @(posedge rd_clk); #1;
    rd_rst_n = 1'b0;
    @(negedge rd_clk); #1;
    check("s6_rst_m_valid", int'(m_valid), 0);
    check("s6_rst_busy", int'(busy), 0);
    check("s6_rst_cmd_ready", int'(cmd_ready), 1);
    @(posedge rd_clk); #1;
    rd_rst_n = 1'b1;
    src_q.delete();
    update_fifo_if();
    push_words(2, 8'h5A, 1'b0);
    send_cmd(2);
    wait_done(50);
    check("s6_beats", n_beats, 2);
    check("s6_first", (beat_q.size() > 0) ? int'(beat_q[0]) : -1, 'h5A);
    check("s6_second", (beat_q.size() > 1) ? int'(beat_q[1]) : -1, 'h5B);
    check("s6_last_count", n_last, 1);
    check("s6_done_count", n_done, 1);

    // randomized lengths, backpressure and FIFO gaps
    @(posedge rd_clk); #1;
    rand_mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int len;
      len = $urandom_range(0, 12);
      push_words(len, 8'h00, 1'b1);
      send_cmd(len);
      wait_done(600);
      check("rnd_beats", n_beats, len);
      check("rnd_pops", n_pops, len);
      check("rnd_done_count", n_done, 1);
    end
    rand_mode = 1'b0;
    check("rnd_bad_pops", bad_pops, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
